div_device: RTL

DIV_DEVICE -- requirements
Module: div_device

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 25 ++
 rtl/div_device.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring sequential divider.
package div_pkg;

    // Default operand widths: 16-bit dividend/quotient, 8-bit divisor/remainder.
    localparam int DIV_DVD_W = 16;
    localparam int DIV_DVS_W = 8;

    // One quotient bit is produced per step, so a full divide takes DVD_W steps.
    localparam int DIV_STEPS = 16;

    // Step counter value of the last step (the counter runs 0..15).
    localparam logic [4:0] DIV_CNT_LAST = 5'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: compare the 9-bit partial remainder against the
// divisor, subtract when it fits and report the resulting quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int DVS_W = DIV_DVS_W
) (
    input  logic [DVS_W:0]   p,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] rem_next,
    output logic             q_bit
);

    // Trial subtraction; the difference is below the divisor so its low bits suffice.
    always_comb begin
        if (p >= {1'b0, divisor}) begin
            rem_next = p[DVS_W-1:0] - divisor;
            q_bit    = 1'b1;
        end else begin
            rem_next = p[DVS_W-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_device.sv
// Unsigned radix-2 restoring sequential divider (16 / 8 -> 16 quotient, 8 remainder).
// Optional build macro DIV_ZERO_DETECT_EN: a zero divisor skips the iteration,
// reports quotient=all ones, remainder=dividend low byte and raises dz.
// Without the macro dz is tied low and a zero divisor runs the normal 16 steps.
module div_device
    import div_pkg::*;
#(
    parameter int DVD_W = DIV_DVD_W,
    parameter int DVS_W = DIV_DVS_W
) (
    input  logic             base_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             dz
);

    div_state_e       state_r;
    div_state_e       state_s;
    logic             accept_s;
    logic             finish_s;
    logic [DVD_W-1:0] dq_r;       // dividend bits shift out the top, quotient bits in the bottom
    logic [DVS_W-1:0] dvs_r;
    logic [DVS_W-1:0] rem_r;
    logic [4:0]       cnt_r;
    logic [DVD_W-1:0] quot_r;
    logic [DVS_W-1:0] remd_r;
    logic             busy_r;
    logic             done_r;
    logic [DVS_W:0]   p_s;
    logic [DVS_W-1:0] rem_next_s;
    logic             q_bit_s;
`ifdef DIV_ZERO_DETECT_EN
    logic             zero_s;
    logic             dz_r;
`endif

    assign p_s = {rem_r, dq_r[DVD_W-1]};

    div_step #(
        .DVS_W(DVS_W)
    ) u_step (
        .p        (p_s),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Next-state and control decode; start is only looked at in IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        zero_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == {DVS_W{1'b0}}) begin
                        zero_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
`else
                    state_s = CALC;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == DIV_CNT_LAST) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge base_clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath, result and status registers.
    always_ff @(posedge base_clk or negedge reset) begin
        if (!reset) begin
            dq_r   <= {DVD_W{1'b0}};
            dvs_r  <= {DVS_W{1'b0}};
            rem_r  <= {DVS_W{1'b0}};
            cnt_r  <= 5'd0;
            quot_r <= {DVD_W{1'b0}};
            remd_r <= {DVS_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_r   <= 1'b0;
`endif
        end else begin
            busy_r <= (state_s == CALC);
`ifdef DIV_ZERO_DETECT_EN
            done_r <= finish_s | zero_s;
`else
            done_r <= finish_s;
`endif
            if (accept_s) begin
                dq_r   <= dividend;
                dvs_r  <= divisor;
                rem_r  <= {DVS_W{1'b0}};
                cnt_r  <= 5'd0;
                quot_r <= {DVD_W{1'b0}};
                remd_r <= {DVS_W{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
                dz_r   <= 1'b0;
                if (zero_s) begin
                    quot_r <= {DVD_W{1'b1}};
                    remd_r <= dividend[DVS_W-1:0];
                    dz_r   <= 1'b1;
                end
`endif
            end else if (state_r == CALC) begin
                dq_r  <= {dq_r[DVD_W-2:0], q_bit_s};
                rem_r <= rem_next_s;
                cnt_r <= cnt_r + 5'd1;
                if (finish_s) begin
                    quot_r <= {dq_r[DVD_W-2:0], q_bit_s};
                    remd_r <= rem_next_s;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = remd_r;
`ifdef DIV_ZERO_DETECT_EN
    assign dz        = dz_r;
`else
    assign dz        = 1'b0;
`endif

endmodule
